// File: rtl/lwh_accel_pkg.sv
// lwh_accel_pkg: shared opcode/state types, status bit positions and sizing constants
package lwh_accel_pkg;
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_READ   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_HASH   = 3'd3,
    OP_CHECK  = 3'd4,
    OP_ABSORB = 3'd5,
    OP_CLEAR  = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_CORE = 2'd2,
    S_STORE     = 2'd3
  } state_e;
  localparam int STATUS_W   = 5;
  localparam int ST_READY   = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_CHAINED = 3;
  localparam int ST_TIMEOUT = 4;
  localparam int MAX_WORDS  = 16;
  localparam int IDX_W      = 4;
endpackage

// File: rtl/lwh_accel_if.sv
// lwh_accel_if: CPU command bus plus LWH core stream, bundled for the accelerator
//   cpu side : op, addr, wdata -> rdata, ready, done, err
//   core side: core_din, core_din_valid, core_first, core_last -> core_dout, core_dout_valid
//   slave modport = accelerator view, master modport = CPU/core view
interface lwh_accel_if #(parameter int DATA_W = 32);
  import lwh_accel_pkg::*;
  op_e               op;
  logic [3:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] core_din;
  logic              core_din_valid;
  logic              core_first;
  logic              core_last;
  logic [DATA_W-1:0] core_dout;
  logic              core_dout_valid;
  modport slave (
    input  op, addr, wdata, core_dout, core_dout_valid,
    output rdata, ready, done, err, core_din, core_din_valid, core_first, core_last
  );
  modport master (
    output op, addr, wdata, core_dout, core_dout_valid,
    input  rdata, ready, done, err, core_din, core_din_valid, core_first, core_last
  );
endinterface

// File: rtl/lwh_accel_wdog.sv
// lwh_accel_wdog: watchdog counter; clr zeroes it, en advances it, expire flags LIMIT reached
//   clk, rst : clock, synchronous active-high reset
//   clr, en  : clear (wins over en), count enable
//   expire   : count has reached LIMIT (holds until cleared)
module lwh_accel_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign expire = cnt == W'(LIMIT);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/lwh_accel.sv
// lwh_accel: command/register front-end for the LWH core (block buffer, digest capture, status)
//   clk, rst : sole clock, synchronous active-high reset
//   bus      : lwh_accel_if.slave carrying CPU commands and the core stream
//   optional : define LWH_ACCEL_TIMEOUT_EN to add a TIMEOUT_CYC watchdog on the core response
module lwh_accel import lwh_accel_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int IN_WORDS    = 8,
  parameter int OUT_WORDS   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic       clk,
  input logic       rst,
  lwh_accel_if.slave bus
);
  localparam logic [IDX_W:0]   IN_N     = (IDX_W+1)'(IN_WORDS);
  localparam logic [IDX_W:0]   OUT_N    = (IDX_W+1)'(OUT_WORDS);
  localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(IN_WORDS - 1);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(OUT_WORDS - 1);
  if (IN_WORDS < 1 || IN_WORDS > MAX_WORDS || OUT_WORDS < 1 || OUT_WORDS > MAX_WORDS || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("lwh_accel: parameter out of range");
  end
  logic [DATA_W-1:0]   in_reg  [MAX_WORDS];
  logic [DATA_W-1:0]   out_reg [MAX_WORDS];
  state_e              state, state_n;
  logic [IDX_W-1:0]    idx;
  logic                done, err, chained, timeout, last_r;
  logic                clear, start, wr_ok, load_end, waiting, cap, fin, expire;
  logic [STATUS_W-1:0] status;
  assign clear    = bus.op == OP_CLEAR;
  assign start    = bus.op == OP_HASH || bus.op == OP_ABSORB;
  assign wr_ok    = state == S_IDLE && {1'b0, bus.addr} < IN_N;
  assign load_end = state == S_LOAD && idx == IN_LAST;
  assign waiting  = state == S_WAIT_CORE || state == S_STORE;
  // idx is zero on entry to WAIT_CORE, so first and later digest words share one capture path
  assign cap      = waiting && bus.core_dout_valid && !expire;
  assign fin      = cap && idx == OUT_LAST;
`ifdef LWH_ACCEL_TIMEOUT_EN
  logic wd_exp;
  lwh_accel_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(clear || bus.core_dout_valid || !waiting),
    .en(waiting),
    .expire(wd_exp)
  );
  assign expire = waiting && wd_exp;
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = clear ? S_IDLE :
              (state == S_IDLE && start) ? S_LOAD :
              load_end ? (last_r ? S_WAIT_CORE : S_IDLE) :
              (expire || fin) ? S_IDLE :
              (cap && state == S_WAIT_CORE) ? S_STORE : state;
  end
  always_comb begin
    status              = '0;
    status[ST_READY]    = state == S_IDLE;
    status[ST_DONE]     = done;
    status[ST_ERR]      = err;
    status[ST_CHAINED]  = chained;
    status[ST_TIMEOUT]  = timeout;
    bus.ready           = state == S_IDLE;
    bus.done            = done;
    bus.err             = err;
    bus.core_din_valid  = state == S_LOAD;
    bus.core_din        = state == S_LOAD ? in_reg[idx] : '0;
    bus.core_first      = state == S_LOAD && idx == '0 && !chained;
    bus.core_last       = state == S_LOAD && last_r;
    bus.rdata           = bus.op == OP_READ ? ({1'b0, bus.addr} < OUT_N ? out_reg[bus.addr] : '0) :
                          bus.op == OP_CHECK ? DATA_W'(status) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        in_reg[i]  <= '0;
        out_reg[i] <= '0;
      end
      idx     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      chained <= 1'b0;
      timeout <= 1'b0;
      last_r  <= 1'b0;
    end else if (clear) begin
      idx     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      chained <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (bus.op == OP_WRITE) begin
        if (wr_ok) in_reg[bus.addr] <= bus.wdata;
        else err <= 1'b1;
      end
      if (start) begin
        if (state == S_IDLE) begin
          done   <= 1'b0;
          idx    <= '0;
          last_r <= bus.op == OP_HASH;
        end else err <= 1'b1;
      end
      if (state == S_LOAD) begin
        idx <= load_end ? '0 : idx + 1'b1;
        if (load_end && !last_r) chained <= 1'b1;
      end
      if (expire) begin
        err     <= 1'b1;
        timeout <= 1'b1;
        chained <= 1'b0;
      end
      if (cap) begin
        out_reg[idx] <= bus.core_dout;
        idx          <= fin ? '0 : idx + 1'b1;
        if (fin) begin
          done    <= 1'b1;
          chained <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_lwh_accel.sv
// tb_lwh_accel: directed self-checking bench for lwh_accel with a hand-driven core model
module tb_lwh_accel;
  import lwh_accel_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] blk [8];
  logic [31:0] v;
  always #5 clk = ~clk;
  lwh_accel_if #(.DATA_W(32)) bus ();
  lwh_accel #(.DATA_W(32), .IN_WORDS(8), .OUT_WORDS(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input op_e o, input logic [3:0] a, input logic [31:0] d);
    bus.op = o;
    bus.addr = a;
    bus.wdata = d;
    tick();
    bus.op = OP_NONE;
  endtask
  task automatic rd(input op_e o, input logic [3:0] a, output logic [31:0] r);
    bus.op = o;
    bus.addr = a;
    #1;
    r = bus.rdata;
    bus.op = OP_NONE;
    tick();
  endtask
  task automatic wr_blk(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 8; i++) begin
      blk[i] = base + step * 32'(i);
      cmd(OP_WRITE, 4'(i), blk[i]);
    end
  endtask
  task automatic run_load(input logic first0, input logic last);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("din_valid%0d", i), 32'(bus.core_din_valid), 32'd1);
      chk($sformatf("din%0d", i), bus.core_din, blk[i]);
      chk($sformatf("first%0d", i), 32'(bus.core_first), 32'(i == 0 ? first0 : 1'b0));
      chk($sformatf("last%0d", i), 32'(bus.core_last), 32'(last));
      tick();
    end
    chk("load_over", 32'(bus.core_din_valid), 32'd0);
  endtask
  task automatic feed(input int n, input logic [31:0] base, input int gap);
    for (int k = 0; k < n; k++) begin
      if (k == gap) begin
        bus.core_dout_valid = 1'b0;
        tick();
        chk("gap_busy", 32'(bus.ready), 32'd0);
      end
      bus.core_dout_valid = 1'b1;
      bus.core_dout = base + 32'(k);
      tick();
    end
    bus.core_dout_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.op = OP_NONE;
    bus.addr = '0;
    bus.wdata = '0;
    bus.core_dout = '0;
    bus.core_dout_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_din_valid", 32'(bus.core_din_valid), 32'd0);
    chk("rst_first", 32'(bus.core_first), 32'd0);
    chk("rst_last", 32'(bus.core_last), 32'd0);
    chk("rst_din", bus.core_din, 32'd0);
    rd(OP_CHECK, 4'd0, v);
    chk("rst_status", v, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd(OP_READ, 4'(i), v);
      chk($sformatf("rst_out%0d", i), v, 32'd0);
    end
    wr_blk(32'h11111111, 32'h11111111);
    cmd(OP_HASH, 4'd0, 32'd0);
    chk("hash_busy", 32'(bus.ready), 32'd0);
    run_load(1'b1, 1'b1);
    feed(8, 32'hA0, 4);
    chk("hash_done", 32'(bus.done), 32'd1);
    chk("hash_ready", 32'(bus.ready), 32'd1);
    rd(OP_READ, 4'd3, v);
    chk("hash_out3", v, 32'hA3);
    rd(OP_CHECK, 4'd0, v);
    chk("hash_status", v, 32'h3);
    wr_blk(32'hA0000000, 32'd1);
    cmd(OP_ABSORB, 4'd0, 32'd0);
    run_load(1'b1, 1'b0);
    rd(OP_CHECK, 4'd0, v);
    chk("chain_status", v, 32'h9);
    wr_blk(32'hB0000000, 32'd1);
    cmd(OP_HASH, 4'd0, 32'd0);
    run_load(1'b0, 1'b1);
    feed(8, 32'hB0, -1);
    rd(OP_CHECK, 4'd0, v);
    chk("chain_done_status", v, 32'h3);
    rd(OP_READ, 4'd7, v);
    chk("chain_out7", v, 32'hB7);
    wr_blk(32'hC0DE0000, 32'd1);
    cmd(OP_HASH, 4'd0, 32'd0);
    cmd(OP_WRITE, 4'd0, 32'hDEADBEEF);
    chk("wr_busy_err", 32'(bus.err), 32'd1);
    cmd(OP_HASH, 4'd0, 32'd0);
    repeat (6) tick();
    feed(8, 32'hC0, -1);
    rd(OP_CHECK, 4'd0, v);
    chk("err_status", v, 32'h7);
    cmd(OP_CLEAR, 4'd0, 32'd0);
    rd(OP_CHECK, 4'd0, v);
    chk("clear_status", v, 32'h1);
    cmd(OP_WRITE, 4'd9, 32'h12345678);
    rd(OP_CHECK, 4'd0, v);
    chk("wr_range_status", v, 32'h5);
    rd(OP_READ, 4'd9, v);
    chk("rd_range", v, 32'd0);
    cmd(OP_CLEAR, 4'd0, 32'd0);
    rd(OP_CHECK, 4'd0, v);
    chk("clear2_status", v, 32'h1);
    bus.core_dout_valid = 1'b1;
    bus.core_dout = 32'hFF;
    tick();
    bus.core_dout_valid = 1'b0;
    rd(OP_READ, 4'd0, v);
    chk("stray_pulse_out0", v, 32'hC0);
    rd(OP_CHECK, 4'd0, v);
    chk("stray_pulse_status", v, 32'h1);
    cmd(OP_HASH, 4'd0, 32'd0);
    run_load(1'b1, 1'b1);
    feed(3, 32'hD0, -1);
    chk("store_busy", 32'(bus.ready), 32'd0);
    cmd(OP_CLEAR, 4'd0, 32'd0);
    rd(OP_CHECK, 4'd0, v);
    chk("abort_status", v, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd(OP_READ, 4'(i), v);
      chk($sformatf("abort_out%0d", i), v, i < 3 ? 32'hD0 + 32'(i) : 32'hC0 + 32'(i));
    end
`ifdef LWH_ACCEL_TIMEOUT_EN
    cmd(OP_HASH, 4'd0, 32'd0);
    repeat (8) tick();
    for (int k = 0; k < 40 && !bus.ready; k++) tick();
    chk("to_ready", 32'(bus.ready), 32'd1);
    chk("to_done", 32'(bus.done), 32'd0);
    rd(OP_CHECK, 4'd0, v);
    chk("to_status", v, 32'h15);
`else
    cmd(OP_HASH, 4'd0, 32'd0);
    repeat (48) tick();
    rd(OP_CHECK, 4'd0, v);
    chk("no_to_status", v, 32'h0);
`endif
    cmd(OP_CLEAR, 4'd0, 32'd0);
    rd(OP_CHECK, 4'd0, v);
    chk("final_status", v, 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/lwh_accel.md
Name: lwh_accel

Overview:
- Parametrised command/register front-end for the lightweight hash (LWH) core, driven by the CPU-side bus.
- Buffers an input block of IN_WORDS words and streams it to the core.
- Captures OUT_WORDS digest words and exposes status.
- Adds multi-block message chaining, error reporting and soft clear.

Parameters:
- DATA_W, 32: bus/core word width.
- IN_WORDS, 8: input block words, range 1..16.
- OUT_WORDS, 8: digest words captured, range 1..16.
- TIMEOUT_CYC, 1024: watchdog limit (used only with LWH_ACCEL_TIMEOUT_EN).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- op  in  3  command opcode.
- addr  in  4  register index.
- wdata  in  DATA_W  WRITE data.
- rdata  out  DATA_W  combinational read/status data.
- ready  out  1  idle, command accepted.
- done  out  1  digest valid.
- err  out  1  sticky error.
- core_din  out  DATA_W  word to core.
- core_din_valid  out  1  core_din valid this cycle.
- core_first  out  1  qualifies the first word of a new message.
- core_last  out  1  level, final block of the message (finalize).
- core_dout  in  DATA_W  digest word.
- core_dout_valid  in  1  digest word valid.

Behaviour:
- Opcodes (3-bit): NONE=0, READ=1, WRITE=2, HASH=3 (final block), CHECK=4, ABSORB=5 (non-final block), CLEAR=6, 7 reserved (treated as NONE).
- Reset state: in_reg and out_reg all 0; state IDLE; idx 0; ready=1; done=0; err=0; chained=0; all core_* outputs 0.
- Priority: rst > CLEAR > other ops.
  - CLEAR in any state aborts: state IDLE, idx 0, done/err/chained/timeout all 0, core outputs 0. in_reg and out_reg are retained.
- rdata:
  - READ with addr<OUT_WORDS returns out_reg[addr]; otherwise 0.
  - CHECK returns status: [0] ready, [1] done, [2] err, [3] chained, [4] timeout, rest 0.
  - Any other op returns 0.
  - READ while busy returns stale out_reg contents; this is legal.
- WRITE:
  - In IDLE with addr<IN_WORDS: in_reg[addr]<=wdata.
  - addr>=IN_WORDS, or not IDLE: write ignored, err<=1.
- HASH/ABSORB:
  - In IDLE: done<=0, idx<=0, state LOAD, ready falls the next cycle.
  - When not IDLE: ignored, err<=1.
- States: IDLE, LOAD, WAIT_CORE, STORE.
- LOAD (accepted at cycle T):
  - On cycles T+1..T+IN_WORDS, core_din_valid=1 and core_din=in_reg[idx], idx++.
  - core_first=1 on word 0 only when chained=0.
  - core_last held = (op was HASH) for the whole LOAD.
  - After the last word: ABSORB -> chained<=1, IDLE. HASH -> WAIT_CORE.
- WAIT_CORE: wait for core_dout_valid. That cycle captures out_reg[0], idx<=1, then STORE. If OUT_WORDS==1, go directly to the finish below.
- STORE:
  - Each core_dout_valid cycle captures out_reg[idx], idx++.
  - A gap in valid stalls without error.
  - After word OUT_WORDS-1: done<=1, chained<=0, IDLE; ready rises on the same edge as done.
- Extra core_dout_valid pulses outside WAIT_CORE/STORE are ignored.
- err, once set, remains set until rst or CLEAR.

Optional Feature:
- Macro: LWH_ACCEL_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in WAIT_CORE/STORE and clears on each core_dout_valid.
  - When it reaches TIMEOUT_CYC: err<=1, timeout<=1, chained<=0, IDLE, done stays 0.
- Undefined:
  - No counter; waits indefinitely.
  - Status bit 4 reads 0.
  - TIMEOUT_CYC is unused.

Decomposition:
- Package lwh_accel_pkg holds:
  - opcode enum (3-bit) and state enum (2-bit);
  - status bit position constants;
  - STATUS_W=5.
- Sub-module lwh_accel_wdog: counter with clear/enable/expire, instantiated only under LWH_ACCEL_TIMEOUT_EN.
- The rest is one module plus the existing LWH core outside it.

Test Plan:
- Reset, then CHECK -> rdata=0x1 (ready only); READ addr 0..7 -> 0.
- WRITE 0x11111111..0x88888888 to addr 0..7, HASH, core model emits 8 words 0xA0..0xA7 -> core_din sequence matches, core_first=1 on word 0 only, core_last=1, done=1, READ addr 3 -> 0xA3, CHECK -> 0x3.
- ABSORB block A then HASH block B -> first LOAD has core_first=1 and core_last=0; CHECK between the blocks shows chained (0x9); second LOAD has core_first=0 and core_last=1; chained=0 after done.
- WRITE during LOAD, WRITE addr 9, and HASH while busy -> each is ignored, err=1, in_reg unchanged; CLEAR -> CHECK = 0x1.
- HASH, then CLEAR mid-STORE after 3 words -> IDLE, done=0, out_reg[0..2] updated, out_reg[3..7] unchanged.
- With LWH_ACCEL_TIMEOUT_EN and TIMEOUT_CYC=16: HASH with no core_dout_valid -> at expiry CHECK = 0x15 (ready, err, timeout), done=0.
